// File: rtl/regfile_reader_if.sv
// Request/response bundle between the register-file reader and its users.
// Requester/consumer drives master; the reader implements slave.
interface regfile_reader_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [NREGS-1:0] req_sel;
    logic             req_burst;
    logic [WIDTH-1:0] data_out;
    logic [IDXW-1:0]  data_idx;
    logic             data_valid;
    logic             data_ready;
    logic             sel_err;
    logic             busy;

    modport master (
        output req_valid, req_sel, req_burst, data_ready,
        input  req_ready, data_out, data_idx, data_valid, sel_err, busy
    );

    modport slave (
        input  req_valid, req_sel, req_burst, data_ready,
        output req_ready, data_out, data_idx, data_valid, sel_err, busy
    );
endinterface

// File: rtl/regfile_reader.sv
// Reads single registers or bursts of all registers from the register file
// into a 2-entry output buffer with a valid/ready handshake.
module regfile_reader #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [NREGS*WIDTH-1:0] Regs,
    regfile_reader_if.slave        bus
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NREGS - 1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_cnt;
    logic [1:0]        r_count;
    logic [WIDTH-1:0]  r_data0;
    logic [WIDTH-1:0]  r_data1;
    logic [IDXW-1:0]   r_idx0;
    logic [IDXW-1:0]   r_idx1;
    logic              r_sel_err;

    logic              w_pop;
    logic              w_can_push;
    logic              w_accept;
    logic              w_onehot;
    logic [IDXW-1:0]   w_sel_idx;
    logic              w_push;
    logic [WIDTH-1:0]  w_pdata;
    logic [IDXW-1:0]   w_pidx;

    // Gated by nReset so no request looks acceptable while reset is held.
    assign bus.req_ready  = nReset & (r_state == S_IDLE) & (r_count < 2'd2);
    assign bus.data_valid = (r_count != 2'd0);
    assign bus.data_out   = (r_count != 2'd0) ? r_data0 : '0;
    assign bus.data_idx   = (r_count != 2'd0) ? r_idx0 : '0;
    assign bus.sel_err    = r_sel_err;
    assign bus.busy       = (r_state == S_BURST);

    always_comb begin
        w_pop      = (r_count != 2'd0) & bus.data_ready;
        w_can_push = (r_count < 2'd2) | w_pop;
        w_accept   = bus.req_valid & bus.req_ready;
        w_onehot   = (bus.req_sel != '0) &&
                     ((bus.req_sel & (bus.req_sel - 1'b1)) == '0);
        w_sel_idx  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.req_sel[i]) w_sel_idx = IDXW'(i);
        end
        w_push  = 1'b0;
        w_pdata = '0;
        w_pidx  = '0;
        if (r_state == S_IDLE && w_accept && !bus.req_burst && w_onehot) begin
            w_push  = 1'b1;
            w_pdata = Regs[int'(w_sel_idx)*WIDTH +: WIDTH];
            w_pidx  = w_sel_idx;
        end else if (r_state == S_BURST && w_can_push) begin
            w_push  = 1'b1;
            w_pdata = Regs[int'(r_cnt)*WIDTH +: WIDTH];
            w_pidx  = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_count   <= 2'd0;
            r_data0   <= '0;
            r_data1   <= '0;
            r_idx0    <= '0;
            r_idx1    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= (r_state == S_IDLE) & w_accept &
                         !bus.req_burst & !w_onehot;

            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && bus.req_burst) begin
                        r_state <= S_BURST;
                        r_cnt   <= '0;
                    end
                end
                S_BURST: begin
                    if (w_can_push) begin
                        if (r_cnt == LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Shift-style FIFO: entry 0 is always the head.
            unique case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= w_pdata;
                        r_idx0  <= w_pidx;
                    end else begin
                        r_data0 <= r_data1;
                        r_idx0  <= r_idx1;
                        r_data1 <= w_pdata;
                        r_idx1  <= w_pidx;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= w_pdata;
                        r_idx0  <= w_pidx;
                    end else begin
                        r_data1 <= w_pdata;
                        r_idx1  <= w_pidx;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_idx0  <= r_idx1;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: reset, single reads, bad selects,
// burst with backpressure, live sampling and reset mid-burst.
module tb_regfile_reader;
    localparam int WIDTH = 8;
    localparam int NREGS = 4;

    logic                   clk;
    logic                   nReset;
    logic [NREGS*WIDTH-1:0] Regs;
    int                     checks;
    int                     failures;

    regfile_reader_if #(.WIDTH(WIDTH), .NREGS(NREGS)) rif ();

    regfile_reader #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk    (clk),
        .nReset (nReset),
        .Regs   (Regs),
        .bus    (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v,
                            input logic [7:0] d, input logic [1:0] i);
        chk({tag, "_valid"}, 32'(rif.data_valid), 32'(v));
        chk({tag, "_data"}, 32'(rif.data_out), 32'(d));
        chk({tag, "_idx"}, 32'(rif.data_idx), 32'(i));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        nReset         = 1'b0;
        Regs           = {8'd7, 8'd6, 8'd5, 8'd4};
        rif.req_valid  = 1'b1;
        rif.req_sel    = 4'b0001;
        rif.req_burst  = 1'b0;
        rif.data_ready = 1'b1;

        tick();
        tick();
        chk_head("rst", 1'b0, 8'd0, 2'd0);
        chk("rst_ready", 32'(rif.req_ready), 32'd0);
        chk("rst_busy", 32'(rif.busy), 32'd0);
        chk("rst_selerr", 32'(rif.sel_err), 32'd0);

        nReset        = 1'b1;
        rif.req_valid = 1'b0;
        tick();
        chk("rel_ready", 32'(rif.req_ready), 32'd1);
        chk("rel_valid", 32'(rif.data_valid), 32'd0);

        rif.req_valid = 1'b1;
        rif.req_sel   = 4'b0010;
        tick();
        chk_head("single_r1", 1'b1, 8'd5, 2'd1);
        rif.req_sel = 4'b1000;
        tick();
        chk_head("single_r3", 1'b1, 8'd7, 2'd3);
        rif.req_valid = 1'b0;
        tick();
        chk_head("single_drain", 1'b0, 8'd0, 2'd0);

        rif.req_valid = 1'b1;
        rif.req_sel   = 4'b0000;
        tick();
        chk("bad0_err", 32'(rif.sel_err), 32'd1);
        chk("bad0_valid", 32'(rif.data_valid), 32'd0);
        chk("bad0_ready", 32'(rif.req_ready), 32'd1);
        rif.req_sel = 4'b0110;
        tick();
        chk("bad6_err", 32'(rif.sel_err), 32'd1);
        chk("bad6_valid", 32'(rif.data_valid), 32'd0);
        chk("bad6_ready", 32'(rif.req_ready), 32'd1);
        rif.req_valid = 1'b0;
        tick();
        chk("bad_clear", 32'(rif.sel_err), 32'd0);
        chk("bad_nopush", 32'(rif.data_valid), 32'd0);

        // Burst under backpressure, with R2 changed while stalled.
        rif.data_ready = 1'b0;
        rif.req_valid  = 1'b1;
        rif.req_burst  = 1'b1;
        tick();
        chk("b_acc_busy", 32'(rif.busy), 32'd1);
        chk("b_acc_valid", 32'(rif.data_valid), 32'd0);
        chk("b_acc_ready", 32'(rif.req_ready), 32'd0);
        rif.req_valid = 1'b0;
        tick();
        chk_head("b_push0", 1'b1, 8'd4, 2'd0);
        tick();
        chk_head("b_full", 1'b1, 8'd4, 2'd0);
        chk("b_full_busy", 32'(rif.busy), 32'd1);
        chk("b_full_ready", 32'(rif.req_ready), 32'd0);
        tick();
        chk_head("b_stall", 1'b1, 8'd4, 2'd0);
        Regs[23:16] = 8'd9;
        tick();
        chk_head("b_stall2", 1'b1, 8'd4, 2'd0);
        chk("b_stall2_busy", 32'(rif.busy), 32'd1);
        rif.data_ready = 1'b1;
        tick();
        chk_head("b_pop1", 1'b1, 8'd5, 2'd1);
        chk("b_pop1_busy", 32'(rif.busy), 32'd1);
        tick();
        chk_head("b_pop2", 1'b1, 8'd9, 2'd2);
        chk("b_done_busy", 32'(rif.busy), 32'd0);
        chk("b_done_ready", 32'(rif.req_ready), 32'd0);
        tick();
        chk_head("b_pop3", 1'b1, 8'd7, 2'd3);
        chk("b_ready_back", 32'(rif.req_ready), 32'd1);
        tick();
        chk_head("b_empty", 1'b0, 8'd0, 2'd0);

        // Reset in the middle of a burst after idx1 is pushed.
        Regs[23:16]    = 8'd6;
        rif.data_ready = 1'b0;
        rif.req_valid  = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        tick();
        tick();
        chk_head("m_full", 1'b1, 8'd4, 2'd0);
        chk("m_full_busy", 32'(rif.busy), 32'd1);
        nReset = 1'b0;
        tick();
        chk_head("m_rst", 1'b0, 8'd0, 2'd0);
        chk("m_rst_busy", 32'(rif.busy), 32'd0);
        chk("m_rst_ready", 32'(rif.req_ready), 32'd0);
        nReset         = 1'b1;
        rif.data_ready = 1'b1;
        tick();
        chk("m_rel_valid", 32'(rif.data_valid), 32'd0);
        chk("m_rel_busy", 32'(rif.busy), 32'd0);
        chk("m_rel_ready", 32'(rif.req_ready), 32'd1);
        tick();
        chk("m_quiet1", 32'(rif.data_valid), 32'd0);
        tick();
        chk("m_quiet2", 32'(rif.data_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
